instr_fetch_unit: RTL

Fetch stage of the 3-stage RISC-V core. Owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, buffers returned instructions in a 2-entry queue, and drives the fetch-side inputs (instruction, PC, PC+4) of the fetch/decode pipeline register. Handles decode-side stalls and taken-branch/jump redirects, including discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to imem and queues
// returned instructions in a 2-entry buffer for the decode stage.
module instr_fetch_unit #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DW-1:0] NOP      = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  output logic          valid_f_o,
  output logic [DW-1:0] instr_f_o,
  output logic [DW-1:0] pc_f_o,
  output logic [DW-1:0] pc_plus_4_f_o
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } fq_t;

  logic [DW-1:0] pc_q;
  logic [1:0]    out_q;
  logic [1:0]    disc_q;

  fq_t           fq_q [2];
  logic          fq_rd_q;
  logic          fq_wr_q;
  logic [1:0]    fq_cnt_q;

  logic [DW-1:0] tq_q [2];
  logic          tq_rd_q;
  logic          tq_wr_q;

  fq_t           head;
  logic          pop;
  logic          gnt;
  logic          rsp;
  logic          drop;
  logic          push;
  logic [2:0]    used;

  assign head      = fq_q[fq_rd_q];
  assign valid_f_o = (fq_cnt_q != 2'd0) & ~redirect_i;
  assign pop       = valid_f_o & ~stall_i;

  // Credit counts both in-flight requests and buffered words.
  assign used = {1'b0, out_q} + {1'b0, fq_cnt_q}
              - {2'b00, pop};

  assign imem_req_o  = rst_i & ~redirect_i & (used < 3'd2);
  assign imem_addr_o = pc_q;

  assign gnt  = imem_req_o & imem_gnt_i;
  assign rsp  = imem_rvalid_i & (out_q != 2'd0);
  assign drop = rsp & (disc_q != 2'd0);
  assign push = rsp & ~drop & ~redirect_i;

  assign instr_f_o     = valid_f_o ? head.instr : NOP;
  assign pc_f_o        = valid_f_o ? head.pc : '0;
  assign pc_plus_4_f_o = valid_f_o ? head.pc + DW'(4) : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q     <= RESET_PC;
      out_q    <= 2'd0;
      disc_q   <= 2'd0;
      fq_rd_q  <= 1'b0;
      fq_wr_q  <= 1'b0;
      fq_cnt_q <= 2'd0;
      tq_rd_q  <= 1'b0;
      tq_wr_q  <= 1'b0;
    end else begin
      out_q <= out_q + {1'b0, gnt} - {1'b0, rsp};
      if (redirect_i) begin
        pc_q     <= redirect_pc_i;
        // Everything still in flight after this cycle is stale.
        disc_q   <= out_q - {1'b0, rsp};
        fq_rd_q  <= 1'b0;
        fq_wr_q  <= 1'b0;
        fq_cnt_q <= 2'd0;
        tq_rd_q  <= 1'b0;
        tq_wr_q  <= 1'b0;
      end else begin
        if (gnt) begin
          pc_q    <= pc_q + DW'(4);
          tq_wr_q <= ~tq_wr_q;
        end
        if (drop)
          disc_q <= disc_q - 2'd1;
        if (push) begin
          fq_wr_q <= ~fq_wr_q;
          tq_rd_q <= ~tq_rd_q;
        end
        if (pop)
          fq_rd_q <= ~fq_rd_q;
        fq_cnt_q <= fq_cnt_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt)
      tq_q[tq_wr_q] <= pc_q;
    if (push)
      fq_q[fq_wr_q] <= '{pc: tq_q[tq_rd_q], instr: imem_rdata_i};
  end

endmodule
